// File: rtl/hilo_unit_if.sv
// Execute-stage request/response bundle for hilo_unit: the valid/busy request
// handshake and the HI/LO read-back signals.
interface hilo_unit_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, a, b,
    input  busy, rdata, hi, lo
  );

  modport slave (
    input  op_valid, op, a, b,
    output busy, rdata, hi, lo
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register pair with a restoring unsigned divider (one quotient bit per cycle).
// Optional single-cycle multu is enabled by defining HILO_MULTU_EN.
module hilo_unit #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  hilo_unit_if.slave bus
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_DIVU  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  state_e             state_q, state_d;
  logic [32:0]        rem_q, rem_d;
  logic [31:0]        dvd_q, dvd_d;
  logic [31:0]        dvs_q, dvs_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  op_e                op_dec;
  logic               accept;
  logic [32:0]        rem_shift;
  logic [32:0]        rem_sub;
  logic               q_bit;
  logic               unused_rem_msb;

  assign op_dec = op_e'(bus.op);
  assign accept = bus.op_valid && (state_q == S_IDLE);

`ifdef HILO_MULTU_EN
  logic [63:0] product;
  assign product = {32'b0, bus.a} * {32'b0, bus.b};
`endif

  // The top remainder bit is shifted out every step, so only [31:0] feeds forward.
  assign unused_rem_msb = rem_q[32];
  assign rem_shift      = {rem_q[31:0], dvd_q[31]};
  assign rem_sub        = rem_shift - {1'b0, dvs_q};
  assign q_bit          = (rem_shift >= {1'b0, dvs_q});

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_dec)
            OP_DIVU: begin
              dvd_d   = bus.a;
              dvs_d   = bus.b;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            OP_MULTU: begin
`ifdef HILO_MULTU_EN
              hi_d = product[63:32];
              lo_d = product[31:0];
`endif
            end
            default: ;
          endcase
        end
      end

      // Quotient bits shift into the vacated low end of the dividend register.
      S_DIV: begin
        rem_d = q_bit ? rem_sub : rem_shift;
        dvd_d = {dvd_q[30:0], q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        lo_d    = dvd_q;
        hi_d    = rem_q[31:0];
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (accept) begin
      if (op_dec == OP_MFHI) begin
        bus.rdata = hi_q;
      end else if (op_dec == OP_MFLO) begin
        bus.rdata = lo_q;
      end
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed plus randomized bench for hilo_unit against an arithmetic HI/LO model.
module tb_hilo_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hilo_unit_if bus ();

  hilo_unit #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.op_valid = 1'b0;
    bus.op       = 3'd0;
    bus.a        = '0;
    bus.b        = '0;
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) begin
      m_lo = 32'hFFFF_FFFF;
      m_hi = a;
    end else begin
      m_lo = a / b;
      m_hi = a % b;
    end
  endfunction

  task automatic run_divu(input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.op_valid = 1'b1;
    bus.op       = 3'd1;
    bus.a        = a;
    bus.b        = b;
    step();
    idle_bus();
    check("divu_busy_start", 32'(bus.busy), 32'd1);
    check("divu_hi_hold", bus.hi, m_hi);
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
      if (n == 16) check("divu_lo_hold", bus.lo, m_lo);
    end
    check("divu_cycles", 32'(n), 32'd33);
    ref_div(a, b);
    check("divu_hi", bus.hi, m_hi);
    check("divu_lo", bus.lo, m_lo);
  endtask

  task automatic single(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_rd;
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    #1;
    exp_rd = (op == 3'd5) ? m_hi : (op == 3'd6) ? m_lo : 32'd0;
    check("rdata", bus.rdata, exp_rd);
    @(posedge clk);
    #1;
    idle_bus();
    if (op == 3'd3) m_hi = a;
    if (op == 3'd4) m_lo = a;
`ifdef HILO_MULTU_EN
    if (op == 3'd2) {m_hi, m_lo} = 64'(a) * 64'(b);
`endif
    check("single_hi", bus.hi, m_hi);
    check("single_lo", bus.lo, m_lo);
    check("single_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    idle_bus();
    rst = 1'b1;
    m_hi = '0;
    m_lo = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    run_divu(32'd100, 32'd7);
    check("div100_7_lo", bus.lo, 32'd14);
    check("div100_7_hi", bus.hi, 32'd2);

    run_divu(32'd5, 32'd0);
    check("div5_0_lo", bus.lo, 32'hFFFF_FFFF);
    check("div5_0_hi", bus.hi, 32'd5);

    single(3'd3, 32'hDEAD_BEEF, 32'd0);
    single(3'd4, 32'h1234_5678, 32'd0);
    single(3'd5, 32'd0, 32'd0);
    single(3'd6, 32'd0, 32'd0);
    bus.op_valid = 1'b1;
    bus.op       = 3'd5;
    #1;
    check("mfhi_const", bus.rdata, 32'hDEAD_BEEF);
    bus.op       = 3'd6;
    #1;
    check("mflo_const", bus.rdata, 32'h1234_5678);
    idle_bus();
    step();

    // mfhi held throughout a divide is only honoured once busy drops
    bus.op_valid = 1'b1;
    bus.op       = 3'd1;
    bus.a        = 32'hFFFF_FFFF;
    bus.b        = 32'd16;
    step();
    bus.op = 3'd5;
    bus.a  = '0;
    bus.b  = '0;
    #1;
    check("held_rdata_busy", bus.rdata, 32'd0);
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
      if (bus.busy) check("held_rdata_busy", bus.rdata, 32'd0);
    end
    check("held_cycles", 32'(n), 32'd33);
    ref_div(32'hFFFF_FFFF, 32'd16);
    check("held_rdata", bus.rdata, 32'h0000_000F);
    check("held_lo", bus.lo, 32'h0FFF_FFFF);
    check("held_rdata_model", bus.rdata, m_hi);
    step();
    check("held_hi_after", bus.hi, m_hi);
    idle_bus();
    step();

    single(3'd3, 32'd9, 32'd0);
    single(3'd4, 32'd9, 32'd0);
    bus.op_valid = 1'b1;
    bus.op       = 3'd1;
    bus.a        = 32'd50;
    bus.b        = 32'd3;
    step();
    idle_bus();
    repeat (9) step();
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    #2;
    rst = 1'b0;
    step();
    run_divu(32'd9, 32'd3);
    check("div9_3_lo", bus.lo, 32'd3);
    check("div9_3_hi", bus.hi, 32'd0);

    single(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef HILO_MULTU_EN
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);
`else
    check("multu_off_hi", bus.hi, 32'd0);
    check("multu_off_lo", bus.lo, 32'd3);
`endif

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if (($urandom_range(0, 1) == 1) && (r_b > 32'd5)) r_a = r_a >> $urandom_range(0, 31);
      if (r_op == 3'd1) run_divu(r_a, r_b);
      else              single(r_op, r_a, r_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
